fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
- Time-shares one FIR MAC engine among NUM_CH independent sample channels.
- Round-robin arbitration selects a channel, issues its sample to the FIR with the matching history bank, collects the result and returns it tagged with the channel id.
- Sits between the channel front-ends and the FIR datapath; owns the FIR input/output handshakes.
- A watchdog recovers from a FIR that never answers.

Parameters:
- DATA_WIDTH, 24, sample/result width in bits.
- NUM_CH, 4, number of requesting channels (>=2).
- CH_WIDTH, $clog2(NUM_CH), width of channel id / bank select.
- TIMEOUT_CYCLES, 64, maximum cycles allowed from issue to FIR result.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_en  in  1  enables new grants; in-flight transactions always complete.
- iv_ch_din  in  NUM_CH*DATA_WIDTH  channel samples; channel k is slice [k*DATA_WIDTH +: DATA_WIDTH].
- iv_ch_din_valid  in  NUM_CH  per-channel sample valid (level).
- ov_ch_din_ready  out  NUM_CH  one-cycle consume pulse to the granted channel.
- ov_ch_dout  out  DATA_WIDTH  filtered result.
- ov_ch_dout_id  out  CH_WIDTH  channel owning ov_ch_dout.
- o_ch_dout_valid  out  1  result valid, held until accepted.
- i_ch_dout_ready  in  1  downstream accepts result.
- ov_fir_din  out  DATA_WIDTH  sample to the FIR.
- o_fir_din_valid  out  1  sample valid to the FIR.
- ov_fir_bank  out  CH_WIDTH  FIR history/weight bank select; stable for the whole transaction.
- i_fir_ready  in  1  FIR consumed the sample (pulse).
- iv_fir_dout  in  DATA_WIDTH  FIR result.
- i_fir_dout_valid  in  1  FIR result valid.
- o_fir_ready  out  1  one-cycle pulse: result taken.
- o_busy  out  1  high in any state other than IDLE.
- o_err_timeout  out  1  sticky watchdog flag, cleared only by i_rst.

Behaviour:
- Reset (async, any state): state=IDLE, round-robin pointer rr_last=NUM_CH-1, all outputs 0, o_err_timeout=0, watchdog counter=0.
- States: IDLE, ISSUE, WAIT_RESULT, DELIVER.
- IDLE:
  - If i_en and |iv_ch_din_valid: grant g = first valid channel searching from rr_last+1 upward, with modular wrap.
  - Same edge: ov_ch_din_ready[g] pulses for 1 cycle; sample latched to ov_fir_din; ov_fir_bank=g; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - o_fir_din_valid=1 while in this state.
  - On i_fir_ready=1, go to WAIT_RESULT; o_fir_din_valid drops on the next cycle.
- WAIT_RESULT:
  - On i_fir_dout_valid=1, register iv_fir_dout into ov_ch_dout and g into ov_ch_dout_id.
  - o_fir_ready=1 for exactly that one cycle; go to DELIVER.
  - A result arriving in ISSUE (before i_fir_ready) is ignored.
- DELIVER:
  - o_ch_dout_valid=1; ov_ch_dout and ov_ch_dout_id held stable.
  - On i_ch_dout_ready=1: rr_last=g, valid drops next cycle, go to IDLE.
  - If i_ch_dout_ready is already high on entry, valid is high for exactly 1 cycle.
- Latency: minimum grant-to-result-valid is 3 cycles (grant edge, ISSUE with same-cycle i_fir_ready, WAIT_RESULT with same-cycle dout_valid). Minimum 4 cycles between successive grants.
- Watchdog:
  - Counter clears on grant and increments every cycle in ISSUE or WAIT_RESULT.
  - Reaching TIMEOUT_CYCLES: o_err_timeout=1 (sticky); o_fir_din_valid deasserts; result discarded; rr_last=g; go to IDLE.
  - No o_ch_dout_valid is produced for that transaction.
- i_en low mid-transaction: no effect until return to IDLE, then no new grant.
- A channel whose valid drops before grant is not granted. Channels with valid low are skipped. Single-requester case: same channel is re-granted every transaction.
- Data is passed unchanged; no arithmetic, no width change.
- o_busy = (state != IDLE), registered.

Test Plan:
- Reset, then ch2 valid with din=24'h00_1234, FIR acks in 1 cycle and returns 24'h0A_BCDE after 18 cycles -> ov_fir_bank=2, one ov_ch_din_ready[2] pulse, ov_ch_dout=24'h0A_BCDE, id=2, one o_fir_ready pulse.
- All 4 channels valid continuously, immediate downstream ready -> grant order 0,1,2,3,0,1; no channel granted twice before all others.
- Only ch1 and ch3 valid -> order 1,3,1,3; ch0 and ch2 never get ov_ch_din_ready.
- FIR never asserts i_fir_dout_valid -> after 64 cycles o_err_timeout=1 and stays 1; state returns to IDLE; next request is served normally.
- Downstream holds i_ch_dout_ready=0 for 10 cycles -> o_ch_dout_valid and data stable for all 10; no new grant until accepted.
- Assert i_rst asynchronously in WAIT_RESULT -> all outputs 0 immediately, no clock edge required; rr_last restarts so ch0 is granted first.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler that time-shares one FIR MAC engine among NUM_CH channels.
// Owns the FIR issue/result handshakes. A watchdog abandons a FIR that never answers.
module fir_channel_scheduler #(
  parameter int DATA_WIDTH     = 24,
  parameter int NUM_CH         = 4,
  parameter int CH_WIDTH       = $clog2(NUM_CH),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] iv_ch_din,
  input  logic [NUM_CH-1:0]            iv_ch_din_valid,
  output logic [NUM_CH-1:0]            ov_ch_din_ready,
  output logic [DATA_WIDTH-1:0]        ov_ch_dout,
  output logic [CH_WIDTH-1:0]          ov_ch_dout_id,
  output logic                         o_ch_dout_valid,
  input  logic                         i_ch_dout_ready,
  output logic [DATA_WIDTH-1:0]        ov_fir_din,
  output logic                         o_fir_din_valid,
  output logic [CH_WIDTH-1:0]          ov_fir_bank,
  input  logic                         i_fir_ready,
  input  logic [DATA_WIDTH-1:0]        iv_fir_dout,
  input  logic                         i_fir_dout_valid,
  output logic                         o_fir_ready,
  output logic                         o_busy,
  output logic                         o_err_timeout
);

  // One spare count of headroom: an ISSUE->WAIT_RESULT move on the last cycle can reach the limit.
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, DELIVER} state_e;

  state_e                  state_q, state_d;
  logic [CH_WIDTH-1:0]     rr_last_q, rr_last_d;
  logic [NUM_CH-1:0]       din_ready_q, din_ready_d;
  logic [DATA_WIDTH-1:0]   fir_din_q, fir_din_d;
  logic                    fir_din_valid_q, fir_din_valid_d;
  logic [CH_WIDTH-1:0]     bank_q, bank_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [CH_WIDTH-1:0]     dout_id_q, dout_id_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    fir_ready_q, fir_ready_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;
  logic [WD_WIDTH-1:0]     wd_q, wd_d;

  logic                    grant_found;
  logic [CH_WIDTH-1:0]     grant_idx;
  logic [CH_WIDTH-1:0]     cand;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic [WD_WIDTH-1:0]     wd_inc;
  logic                    wd_expired;

  // Search upward from the channel after the last one served, wrapping modulo NUM_CH.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_WIDTH'((int'(rr_last_q) + k) % NUM_CH);
      if (!grant_found && iv_ch_din_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_data = iv_ch_din[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign wd_inc     = wd_q + 1'b1;
  assign wd_expired = (wd_inc >= WD_WIDTH'(TIMEOUT_CYCLES));

  always_comb begin
    state_d         = state_q;
    rr_last_d       = rr_last_q;
    din_ready_d     = '0;
    fir_din_d       = fir_din_q;
    fir_din_valid_d = fir_din_valid_q;
    bank_d          = bank_q;
    dout_d          = dout_q;
    dout_id_d       = dout_id_q;
    dout_valid_d    = dout_valid_q;
    fir_ready_d     = 1'b0;
    err_d           = err_q;
    wd_d            = wd_q;

    unique case (state_q)
      IDLE: begin
        if (i_en && grant_found) begin
          din_ready_d     = NUM_CH'(1) << grant_idx;
          fir_din_d       = grant_data;
          fir_din_valid_d = 1'b1;
          bank_d          = grant_idx;
          wd_d            = '0;
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        wd_d = wd_inc;
        if (i_fir_ready) begin
          fir_din_valid_d = 1'b0;
          state_d         = WAIT_RESULT;
        end else if (wd_expired) begin
          err_d           = 1'b1;
          fir_din_valid_d = 1'b0;
          rr_last_d       = bank_q;
          state_d         = IDLE;
        end
      end
      WAIT_RESULT: begin
        wd_d = wd_inc;
        // A result on the final watchdog cycle still counts as an answer.
        if (i_fir_dout_valid) begin
          dout_d       = iv_fir_dout;
          dout_id_d    = bank_q;
          dout_valid_d = 1'b1;
          fir_ready_d  = 1'b1;
          state_d      = DELIVER;
        end else if (wd_expired) begin
          err_d     = 1'b1;
          rr_last_d = bank_q;
          state_d   = IDLE;
        end
      end
      DELIVER: begin
        if (i_ch_dout_ready) begin
          dout_valid_d = 1'b0;
          rr_last_d    = bank_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= IDLE;
      rr_last_q       <= CH_WIDTH'(NUM_CH - 1);
      din_ready_q     <= '0;
      fir_din_q       <= '0;
      fir_din_valid_q <= 1'b0;
      bank_q          <= '0;
      dout_q          <= '0;
      dout_id_q       <= '0;
      dout_valid_q    <= 1'b0;
      fir_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      wd_q            <= '0;
    end else begin
      state_q         <= state_d;
      rr_last_q       <= rr_last_d;
      din_ready_q     <= din_ready_d;
      fir_din_q       <= fir_din_d;
      fir_din_valid_q <= fir_din_valid_d;
      bank_q          <= bank_d;
      dout_q          <= dout_d;
      dout_id_q       <= dout_id_d;
      dout_valid_q    <= dout_valid_d;
      fir_ready_q     <= fir_ready_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      wd_q            <= wd_d;
    end
  end

  assign ov_ch_din_ready = din_ready_q;
  assign ov_fir_din      = fir_din_q;
  assign o_fir_din_valid = fir_din_valid_q;
  assign ov_fir_bank     = bank_q;
  assign ov_ch_dout      = dout_q;
  assign ov_ch_dout_id   = dout_id_q;
  assign o_ch_dout_valid = dout_valid_q;
  assign o_fir_ready     = fir_ready_q;
  assign o_busy          = busy_q;
  assign o_err_timeout   = err_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level round-robin model.
module tb_fir_channel_scheduler;

  localparam int DW  = 24;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int TMO = 64;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_en;
  logic [NCH*DW-1:0]  iv_ch_din;
  logic [NCH-1:0]     iv_ch_din_valid;
  logic [NCH-1:0]     ov_ch_din_ready;
  logic [DW-1:0]      ov_ch_dout;
  logic [CHW-1:0]     ov_ch_dout_id;
  logic               o_ch_dout_valid;
  logic               i_ch_dout_ready;
  logic [DW-1:0]      ov_fir_din;
  logic               o_fir_din_valid;
  logic [CHW-1:0]     ov_fir_bank;
  logic               i_fir_ready;
  logic [DW-1:0]      iv_fir_dout;
  logic               i_fir_dout_valid;
  logic               o_fir_ready;
  logic               o_busy;
  logic               o_err_timeout;

  always #5 i_clk = ~i_clk;

  fir_channel_scheduler #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(CHW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
    .iv_ch_din(iv_ch_din), .iv_ch_din_valid(iv_ch_din_valid), .ov_ch_din_ready(ov_ch_din_ready),
    .ov_ch_dout(ov_ch_dout), .ov_ch_dout_id(ov_ch_dout_id), .o_ch_dout_valid(o_ch_dout_valid),
    .i_ch_dout_ready(i_ch_dout_ready), .ov_fir_din(ov_fir_din), .o_fir_din_valid(o_fir_din_valid),
    .ov_fir_bank(ov_fir_bank), .i_fir_ready(i_fir_ready), .iv_fir_dout(iv_fir_dout),
    .i_fir_dout_valid(i_fir_dout_valid), .o_fir_ready(o_fir_ready), .o_busy(o_busy),
    .o_err_timeout(o_err_timeout)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model state
  bit            chValid[NCH];
  logic [DW-1:0] chSample[NCH];
  int            lastServed, curCh, wdCount, ackWait, resWait;
  bit            inFlight, acked, resultHeld, errModel;
  logic [DW-1:0] resData;
  int            grantLog[$];
  int            deliveries, firPulseSeen, validHighCount;
  int            readyPulses[NCH];
  logic [DW-1:0] obsDout;
  int            obsId;

  // Stimulus knobs
  int            chReqPct, chDropPct, chStayPct, enPct;
  int            ackDelayMax, resDelayMin, resDelayMax, dsMode, dsHoldLeft;
  bit            noResult, bogusEn, fixedEn;
  logic [DW-1:0] fixedData;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic driveChannels();
    for (int c = 0; c < NCH; c++) begin
      iv_ch_din[c*DW +: DW] = chSample[c];
      iv_ch_din_valid[c]    = chValid[c];
    end
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < NCH; c++) begin
      if (!chValid[c]) begin
        if ($urandom_range(99, 0) < chReqPct) begin
          chValid[c]  = 1'b1;
          chSample[c] = DW'($urandom);
        end
      end else if ($urandom_range(99, 0) < chDropPct) begin
        chValid[c] = 1'b0;
      end
    end
    driveChannels();
    i_en = ($urandom_range(99, 0) < enPct);
    if (inFlight && !acked && !i_fir_ready) begin
      if (ackWait == 0) i_fir_ready = 1'b1;
      else ackWait--;
    end
    if (inFlight && acked && !resultHeld && !i_fir_dout_valid && !noResult) begin
      if (resWait == 0) begin
        i_fir_dout_valid = 1'b1;
        iv_fir_dout      = fixedEn ? fixedData : DW'($urandom);
      end else resWait--;
    end else if (bogusEn && inFlight && !acked && $urandom_range(7, 0) == 0) begin
      i_fir_dout_valid = 1'b1;
      iv_fir_dout      = DW'($urandom);
    end
    case (dsMode)
      0: i_ch_dout_ready = 1'($urandom_range(1, 0));
      1: i_ch_dout_ready = 1'b1;
      default: begin
        i_ch_dout_ready = resultHeld && (dsHoldLeft == 0);
        if (resultHeld && dsHoldLeft > 0) dsHoldLeft--;
      end
    endcase
  endtask

  // One clock: infer what happened at the edge from the inputs the DUT saw, then compare.
  task automatic step();
    logic [NCH-1:0] expReady;
    int g;
    bit inPre, ackedPre, heldPre;
    @(posedge i_clk);
    #1;
    inPre = inFlight; ackedPre = acked; heldPre = resultHeld;
    expReady = '0;
    g = -1;
    if (!inPre && i_en) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (lastServed + k) % NCH;
        if (g < 0 && chValid[c]) g = c;
      end
      if (g >= 0) expReady[g] = 1'b1;
    end
    checkOutput("din_ready", ov_ch_din_ready, expReady);
    for (int c = 0; c < NCH; c++) readyPulses[c] += int'(ov_ch_din_ready[c]);
    if (g >= 0) begin
      checkOutput("fir_din", ov_fir_din, chSample[g]);
      grantLog.push_back(g);
      inFlight = 1'b1; curCh = g; acked = 1'b0; wdCount = 0; firPulseSeen = 0;
      ackWait = $urandom_range(ackDelayMax, 0);
      chSample[g] = DW'($urandom);
      if ($urandom_range(99, 0) >= chStayPct) chValid[g] = 1'b0;
    end
    if (o_fir_ready) firPulseSeen++;
    if (o_ch_dout_valid) begin
      validHighCount++;
      obsDout = ov_ch_dout;
      obsId   = int'(ov_ch_dout_id);
    end
    if (heldPre && i_ch_dout_ready) begin
      resultHeld = 1'b0; inFlight = 1'b0; lastServed = curCh; deliveries++;
      checkOutput("fir_ready_pulses", firPulseSeen, 1);
    end
    if (i_fir_ready) begin
      acked = 1'b1; i_fir_ready = 1'b0;
      resWait = $urandom_range(resDelayMax, resDelayMin);
    end
    if (i_fir_dout_valid) begin
      if (ackedPre && inPre && !heldPre) begin
        checkOutput("fir_ready_take", o_fir_ready, 1);
        resultHeld = 1'b1; resData = iv_fir_dout;
      end else checkOutput("fir_ready_ignore", o_fir_ready, 0);
      i_fir_dout_valid = 1'b0;
    end else checkOutput("fir_ready_idle", o_fir_ready, 0);
    if (g < 0 && inFlight && !resultHeld) begin
      wdCount++;
      if (wdCount >= TMO) begin
        errModel = 1'b1; inFlight = 1'b0; acked = 1'b0; lastServed = curCh;
      end
    end
    checkOutput("busy", o_busy, inFlight);
    checkOutput("err", o_err_timeout, errModel);
    checkOutput("fir_din_valid", o_fir_din_valid, inFlight && !acked);
    checkOutput("dout_valid", o_ch_dout_valid, resultHeld);
    if (resultHeld) begin
      checkOutput("dout", ov_ch_dout, resData);
      checkOutput("dout_id", ov_ch_dout_id, curCh);
    end
    if (inFlight) checkOutput("bank", ov_fir_bank, curCh);
    applyStimulus();
  endtask

  task automatic doReset();
    i_rst = 1'b1; i_en = 1'b0; i_ch_dout_ready = 1'b0; i_fir_ready = 1'b0;
    i_fir_dout_valid = 1'b0; iv_fir_dout = '0;
    for (int c = 0; c < NCH; c++) begin
      chValid[c] = 1'b0; chSample[c] = '0; readyPulses[c] = 0;
    end
    driveChannels();
    lastServed = NCH - 1; inFlight = 0; acked = 0; resultHeld = 0; errModel = 0;
    grantLog.delete(); deliveries = 0; validHighCount = 0; firPulseSeen = 0;
    chReqPct = 0; chDropPct = 0; chStayPct = 0; enPct = 100; ackDelayMax = 0;
    resDelayMin = 0; resDelayMax = 0; dsMode = 1; dsHoldLeft = 0;
    noResult = 0; bogusEn = 0; fixedEn = 0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_din_ready", ov_ch_din_ready, 0);
    checkOutput("rst_fir_valid", o_fir_din_valid, 0);
    checkOutput("rst_dout_valid", o_ch_dout_valid, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_err", o_err_timeout, 0);
    checkOutput("rst_dout", ov_ch_dout, 0);
    checkOutput("rst_bank", ov_fir_bank, 0);
    #2 i_rst = 1'b0;
  endtask

  task automatic runUntilGrants(input int n, input int budget);
    int cnt = 0;
    while (grantLog.size() < n && cnt < budget) begin step(); cnt++; end
    checkOutput("grants_reached", grantLog.size(), n);
  endtask

  task automatic runUntilDeliveries(input int n, input int budget);
    int cnt = 0;
    while (deliveries < n && cnt < budget) begin step(); cnt++; end
    checkOutput("deliveries_reached", deliveries, n);
  endtask

  initial begin
    int cnt;
    doReset();

    $display("[TB] single request on ch2, slow FIR result");
    chValid[2] = 1; chSample[2] = 24'h001234; driveChannels(); i_en = 1;
    fixedEn = 1; fixedData = 24'h0ABCDE; resDelayMin = 18; resDelayMax = 18;
    runUntilDeliveries(1, 200);
    checkOutput("t1_grant", grantLog[0], 2);
    checkOutput("t1_ready_pulses", readyPulses[2], 1);
    checkOutput("t1_dout", obsDout, 24'h0ABCDE);
    checkOutput("t1_id", obsId, 2);

    $display("[TB] all channels requesting");
    doReset();
    for (int c = 0; c < NCH; c++) begin chValid[c] = 1; chSample[c] = DW'($urandom); end
    driveChannels(); i_en = 1; chStayPct = 100;
    runUntilGrants(6, 100);
    for (int i = 0; i < 6; i++) checkOutput("t2_order", grantLog[i], i % NCH);

    $display("[TB] ch1 and ch3 only");
    doReset();
    chValid[1] = 1; chValid[3] = 1; chSample[1] = 24'h111111; chSample[3] = 24'h333333;
    driveChannels(); i_en = 1; chStayPct = 100;
    runUntilGrants(4, 100);
    for (int i = 0; i < 4; i++) checkOutput("t3_order", grantLog[i], (i % 2 == 0) ? 1 : 3);
    checkOutput("t3_ch0_ready", readyPulses[0], 0);
    checkOutput("t3_ch2_ready", readyPulses[2], 0);

    $display("[TB] FIR never answers");
    doReset();
    chValid[0] = 1; chSample[0] = 24'h00ABCD; driveChannels(); i_en = 1; noResult = 1;
    cnt = 0;
    while (!errModel && cnt < 200) begin step(); cnt++; end
    checkOutput("t4_err", o_err_timeout, 1);
    checkOutput("t4_idle", o_busy, 0);
    noResult = 0;
    chValid[1] = 1; chSample[1] = 24'h000777; driveChannels();
    runUntilDeliveries(1, 100);
    checkOutput("t4_next_id", obsId, 1);
    checkOutput("t4_err_sticky", o_err_timeout, 1);

    $display("[TB] downstream backpressure");
    doReset();
    chValid[0] = 1; chValid[1] = 1; chValid[2] = 1; chSample[0] = 24'h0C0FFE;
    driveChannels(); i_en = 1; chStayPct = 100; dsMode = 2; dsHoldLeft = 10; resDelayMax = 2;
    runUntilDeliveries(1, 100);
    checkOutput("t5_valid_cycles", validHighCount, 11);
    checkOutput("t5_single_grant", grantLog.size(), 1);

    $display("[TB] async reset while waiting for FIR result");
    doReset();
    chValid[2] = 1; chSample[2] = 24'h0F0F0F; driveChannels(); i_en = 1; noResult = 1;
    cnt = 0;
    while (!(inFlight && acked) && cnt < 50) begin step(); cnt++; end
    checkOutput("t6_in_wait", o_busy, 1);
    #3 i_rst = 1'b1;
    #1;
    checkOutput("t6_async_busy", o_busy, 0);
    checkOutput("t6_async_bank", ov_fir_bank, 0);
    checkOutput("t6_async_fir_din", ov_fir_din, 0);
    checkOutput("t6_async_fir_valid", o_fir_din_valid, 0);
    doReset();
    for (int c = 0; c < NCH; c++) chValid[c] = 1;
    driveChannels(); i_en = 1; chStayPct = 100;
    runUntilGrants(1, 20);
    checkOutput("t6_first_grant", grantLog[0], 0);

    $display("[TB] randomized traffic");
    doReset();
    chReqPct = 30; chDropPct = 10; chStayPct = 50; enPct = 85; ackDelayMax = 3;
    resDelayMin = 0; resDelayMax = 8; bogusEn = 1; dsMode = 0;
    repeat (3000) step();
    checkOutput("rand_progress", deliveries > 50, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
